// File: rtl/pattern_playback.sv
// Plays a latched 3-bit symbol pattern on one-hot LEDs with fixed on/gap timing.
// All outputs are registered; the output values are computed together with the state transition.
module pattern_playback #(
  parameter int unsigned MAX_LEN    = 25,
  parameter int unsigned ON_CYCLES  = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_reverse,
  input  logic [4:0]             i_length,
  input  logic [3*MAX_LEN-1:0]   i_pattern,
  output logic [7:0]             o_led,
  output logic [4:0]             o_sym_idx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int unsigned PatW     = 3 * MAX_LEN;
  localparam int unsigned MaxDwell = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW     = $clog2(MaxDwell + 1);
  localparam logic [CntW-1:0] OnLoad  = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] GapLoad = CntW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StOn, StGap, StDone} state_e;

  state_e          r_state;
  logic [PatW-1:0] r_pattern;
  logic            r_reverse;
  logic [4:0]      r_len;
  logic [4:0]      r_k;
  logic [CntW-1:0] r_cnt;

  logic [4:0] w_len_clamped;
  assign w_len_clamped = (i_length > 5'(MAX_LEN)) ? 5'(MAX_LEN) : i_length;

  // Forward play shows the oldest symbol (highest index) first.
  function automatic logic [7:0] f_led(input logic [PatW-1:0] pat, input logic rev,
                                       input logic [4:0] len, input logic [4:0] k);
    logic [4:0] idx;
    idx = rev ? k : (len - 5'd1 - k);
    return 8'b1 << pat[32'(idx)*3 +: 3];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_pattern <= '0;
      r_reverse <= 1'b0;
      r_len     <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      o_led     <= '0;
      o_sym_idx <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (r_state != StIdle && i_abort) begin
        r_state   <= StIdle;
        r_k       <= '0;
        r_cnt     <= '0;
        o_led     <= '0;
        o_sym_idx <= '0;
        o_busy    <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start && !i_abort) begin
              r_pattern <= i_pattern;
              r_reverse <= i_reverse;
              r_len     <= w_len_clamped;
              r_k       <= '0;
              o_sym_idx <= '0;
              o_busy    <= 1'b1;
              if (w_len_clamped == 5'd0) begin
                r_state <= StDone;
                o_done  <= 1'b1;
                o_led   <= '0;
              end else begin
                r_state <= StOn;
                r_cnt   <= OnLoad;
                o_led   <= f_led(i_pattern, i_reverse, w_len_clamped, 5'd0);
              end
            end
          end
          StOn: begin
            if (r_cnt == '0) begin
              r_state <= StGap;
              r_cnt   <= GapLoad;
              o_led   <= '0;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          StGap: begin
            if (r_cnt == '0) begin
              if (r_k == r_len - 5'd1) begin
                r_state   <= StDone;
                o_done    <= 1'b1;
                o_sym_idx <= '0;
              end else begin
                r_state   <= StOn;
                r_k       <= r_k + 5'd1;
                o_sym_idx <= r_k + 5'd1;
                r_cnt     <= OnLoad;
                o_led     <= f_led(r_pattern, r_reverse, r_len, r_k + 5'd1);
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          StDone: begin
            r_state   <= StIdle;
            r_k       <= '0;
            o_led     <= '0;
            o_sym_idx <= '0;
            o_busy    <= 1'b0;
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pattern_playback.sv
// Self-checking bench: per-cycle expected outputs are generated from the symbol/timing rules.
module tb_pattern_playback;

  localparam int ML  = 25;
  localparam int ON  = 4;
  localparam int GAP = 2;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_abort, i_reverse;
  logic [4:0]    i_length;
  logic [74:0]   i_pattern;
  logic [7:0]    o_led;
  logic [4:0]    o_sym_idx;
  logic          o_busy, o_done;

  int tests = 0;
  int fails = 0;

  logic [7:0] q_led[$];
  int         q_idx[$];
  bit         q_busy[$];
  bit         q_done[$];

  pattern_playback #(.MAX_LEN(ML), .ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_reverse(i_reverse), .i_length(i_length), .i_pattern(i_pattern),
    .o_led(o_led), .o_sym_idx(o_sym_idx), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic void push_exp(input logic [7:0] led, input int idx, input bit busy,
                                   input bit done);
    q_led.push_back(led);
    q_idx.push_back(idx);
    q_busy.push_back(busy);
    q_done.push_back(done);
  endfunction

  // Expected outputs from cycle T+1 onward; idx -1 means "don't care".
  function automatic void build_expect(input logic [74:0] pat, input bit rev, input int len,
                                       input int tail);
    int l, s, sym;
    logic [74:0] sh;
    q_led.delete(); q_idx.delete(); q_busy.delete(); q_done.delete();
    l = (len > ML) ? ML : len;
    for (int k = 0; k < l; k++) begin
      s   = rev ? k : l - 1 - k;
      sh  = pat >> (3 * s);
      sym = int'(sh[2:0]);
      for (int c = 0; c < ON; c++) push_exp(8'(1 << sym), k, 1'b1, 1'b0);
      for (int c = 0; c < GAP; c++) push_exp(8'h00, k, 1'b1, 1'b0);
    end
    push_exp(8'h00, -1, 1'b1, 1'b1);
    for (int t = 0; t < tail; t++) push_exp(8'h00, 0, 1'b0, 1'b0);
  endfunction

  // Called at a negedge; returns at the negedge where cycle T+1 is visible.
  task automatic kick(input logic [74:0] pat, input bit rev, input logic [4:0] len);
    i_pattern = pat;
    i_reverse = rev;
    i_length  = len;
    i_start   = 1'b1;
    @(negedge i_clk);
    i_start   = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_reverse = 1'b0;
    i_length = '0; i_pattern = '0;
    repeat (3) @(negedge i_clk);
    tests++;
    if (o_led !== 8'h00 || o_sym_idx !== 5'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      fails++;
      $display("FAIL reset: led=%h idx=%0d busy=%b done=%b, expected all zero",
               o_led, o_sym_idx, o_busy, o_done);
    end
    i_rst = 1'b0;
    @(negedge i_clk);
    tests++;
    if (o_busy !== 1'b0 || o_led !== 8'h00) begin
      fails++;
      $display("FAIL reset_idle: busy=%b led=%h, expected 0 and 00", o_busy, o_led);
    end
  endtask

  task automatic test_forward();
    build_expect(75'(9'b101_010_111), 1'b0, 3, 2);
    kick(75'(9'b101_010_111), 1'b0, 5'd3);
    for (int i = 0; i < q_led.size(); i++) begin
      if (i > 0) @(negedge i_clk);
      tests++;
      if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i] ||
          (q_idx[i] >= 0 && o_sym_idx !== 5'(q_idx[i]))) begin
        fails++;
        $display("FAIL forward T+%0d: led=%h idx=%0d busy=%b done=%b, expected led=%h idx=%0d busy=%b done=%b",
                 i + 1, o_led, o_sym_idx, o_busy, o_done, q_led[i], q_idx[i], q_busy[i], q_done[i]);
      end
    end
  endtask

  task automatic test_reverse();
    build_expect(75'(9'b101_010_111), 1'b1, 3, 2);
    kick(75'(9'b101_010_111), 1'b1, 5'd3);
    for (int i = 0; i < q_led.size(); i++) begin
      if (i > 0) @(negedge i_clk);
      tests++;
      if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i] ||
          (q_idx[i] >= 0 && o_sym_idx !== 5'(q_idx[i]))) begin
        fails++;
        $display("FAIL reverse T+%0d: led=%h idx=%0d busy=%b done=%b, expected led=%h idx=%0d busy=%b done=%b",
                 i + 1, o_led, o_sym_idx, o_busy, o_done, q_led[i], q_idx[i], q_busy[i], q_done[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    build_expect({75{1'b1}}, 1'b0, 0, 4);
    kick({75{1'b1}}, 1'b0, 5'd0);
    for (int i = 0; i < q_led.size(); i++) begin
      if (i > 0) @(negedge i_clk);
      tests++;
      if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i]) begin
        fails++;
        $display("FAIL zero_len T+%0d: led=%h busy=%b done=%b, expected led=%h busy=%b done=%b",
                 i + 1, o_led, o_busy, o_done, q_led[i], q_busy[i], q_done[i]);
      end
    end
  endtask

  task automatic test_over_len();
    build_expect({75{1'b1}}, 1'b0, 31, 2);
    kick({75{1'b1}}, 1'b0, 5'd31);
    for (int i = 0; i < q_led.size(); i++) begin
      if (i > 0) @(negedge i_clk);
      tests++;
      if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i] ||
          (q_idx[i] >= 0 && o_sym_idx !== 5'(q_idx[i]))) begin
        fails++;
        $display("FAIL over_len T+%0d: led=%h idx=%0d busy=%b done=%b, expected led=%h idx=%0d busy=%b done=%b",
                 i + 1, o_led, o_sym_idx, o_busy, o_done, q_led[i], q_idx[i], q_busy[i], q_done[i]);
      end
    end
  endtask

  // Random playbacks; inputs are scrambled and start pulsed while busy, which must not matter.
  task automatic test_random_latched();
    logic [74:0] p;
    bit          r;
    int          l;
    for (int n = 0; n < 8; n++) begin
      p = 75'({$urandom(), $urandom(), $urandom()});
      r = 1'($urandom_range(0, 1));
      l = int'($urandom_range(0, 31));
      build_expect(p, r, l, 2);
      kick(p, r, 5'(l));
      for (int i = 0; i < q_led.size(); i++) begin
        if (i > 0) @(negedge i_clk);
        tests++;
        if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i] ||
            (q_idx[i] >= 0 && o_sym_idx !== 5'(q_idx[i]))) begin
          fails++;
          $display("FAIL random%0d T+%0d: led=%h idx=%0d busy=%b done=%b, expected led=%h idx=%0d busy=%b done=%b",
                   n, i + 1, o_led, o_sym_idx, o_busy, o_done, q_led[i], q_idx[i], q_busy[i],
                   q_done[i]);
        end
        if (q_busy[i]) begin
          i_pattern = 75'({$urandom(), $urandom(), $urandom()});
          i_reverse = 1'($urandom_range(0, 1));
          i_length  = 5'($urandom_range(0, 31));
          i_start   = 1'($urandom_range(0, 1));
        end else begin
          i_start = 1'b0;
        end
      end
      i_start = 1'b0;
    end
  endtask

  task automatic test_abort();
    bit bad;
    build_expect(75'(9'b101_010_111), 1'b0, 3, 1);
    kick(75'(9'b101_010_111), 1'b0, 5'd3);
    // Cycle T+8 is inside the second ON phase.
    repeat (7) @(negedge i_clk);
    tests++;
    if (o_led !== 8'h04 || o_sym_idx !== 5'd1) begin
      fails++;
      $display("FAIL abort_pre: led=%h idx=%0d, expected 04 and 1", o_led, o_sym_idx);
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    tests++;
    if (o_led !== 8'h00 || o_busy !== 1'b0 || o_done !== 1'b0 || o_sym_idx !== 5'd0) begin
      fails++;
      $display("FAIL abort_now: led=%h busy=%b done=%b idx=%0d, expected 00 0 0 0",
               o_led, o_busy, o_done, o_sym_idx);
    end
    bad = 1'b0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_led !== 8'h00) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL abort_quiet: activity seen after abort, expected none");
    end
    // abort together with start in IDLE must not start anything.
    i_abort = 1'b1;
    kick(75'(9'b101_010_111), 1'b0, 5'd3);
    i_abort = 1'b0;
    tests++;
    if (o_busy !== 1'b0 || o_led !== 8'h00) begin
      fails++;
      $display("FAIL abort_start: busy=%b led=%h, expected 0 and 00", o_busy, o_led);
    end
    kick(75'(9'b101_010_111), 1'b0, 5'd3);
    for (int i = 0; i < q_led.size(); i++) begin
      if (i > 0) @(negedge i_clk);
      tests++;
      if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i] ||
          (q_idx[i] >= 0 && o_sym_idx !== 5'(q_idx[i]))) begin
        fails++;
        $display("FAIL restart T+%0d: led=%h idx=%0d busy=%b done=%b, expected led=%h idx=%0d busy=%b done=%b",
                 i + 1, o_led, o_sym_idx, o_busy, o_done, q_led[i], q_idx[i], q_busy[i], q_done[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    build_expect(75'(9'b011_110), 1'b1, 2, 1);
    kick(75'(9'b011_110), 1'b1, 5'd2);
    for (int i = 0; i < q_led.size(); i++) begin
      if (i > 0) @(negedge i_clk);
      tests++;
      if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i]) begin
        fails++;
        $display("FAIL b2b_first T+%0d: led=%h busy=%b done=%b, expected led=%h busy=%b done=%b",
                 i + 1, o_led, o_busy, o_done, q_led[i], q_busy[i], q_done[i]);
      end
    end
    // Start on the very first cycle busy reads 0.
    build_expect(75'(6'b001_100), 1'b0, 2, 2);
    kick(75'(6'b001_100), 1'b0, 5'd2);
    for (int i = 0; i < q_led.size(); i++) begin
      if (i > 0) @(negedge i_clk);
      tests++;
      if (o_led !== q_led[i] || o_busy !== q_busy[i] || o_done !== q_done[i] ||
          (q_idx[i] >= 0 && o_sym_idx !== 5'(q_idx[i]))) begin
        fails++;
        $display("FAIL b2b_second T+%0d: led=%h idx=%0d busy=%b done=%b, expected led=%h idx=%0d busy=%b done=%b",
                 i + 1, o_led, o_sym_idx, o_busy, o_done, q_led[i], q_idx[i], q_busy[i], q_done[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    kick(75'(9'b101_010_111), 1'b0, 5'd3);
    // Cycle T+6 is the first GAP phase.
    repeat (5) @(negedge i_clk);
    tests++;
    if (o_led !== 8'h00 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_pre: led=%h busy=%b, expected 00 and 1", o_led, o_busy);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    tests++;
    if (o_led !== 8'h00 || o_busy !== 1'b0 || o_sym_idx !== 5'd0 || o_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: led=%h busy=%b idx=%0d done=%b, expected 00 0 0 0",
               o_led, o_busy, o_sym_idx, o_done);
    end
    repeat (3) @(negedge i_clk);
    tests++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: busy=%b done=%b, expected 0 0", o_busy, o_done);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_zero_len();
    test_over_len();
    test_random_latched();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
